// File: rtl/regbank_pkg.sv
// regbank_pkg: shared defaults for the ID-stage register bank.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default register width and index width
//   reg_idx_t                       : register index at the default width
package regbank_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: per-register pending-write flags.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   set_en, set_idx: issue of a new producer for set_idx
//   clr_en, clr_idx: writeback retiring the producer of clr_idx
//   busy_vec       : registered scoreboard, bit i = register i pending
//   busy_next      : value busy_vec takes at the coming edge
module regbank_scoreboard import regbank_pkg::*; #(
  parameter  int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int unsigned ZERO_REG   = 1,
  localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [NUM_REGS-1:0]   busy_next
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a new producer of the same register
  // supersedes the one retiring on this edge.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_vec  = busy_q;
  assign busy_next = busy_d;

endmodule

// File: rtl/regbank_param.sv
// regbank_param: ID-stage register bank.
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   rd_en, rs, rt        : capture read ports A/B this cycle
//   data1, data2         : registered read data (write-forwarded)
//   busy1, busy2         : registered pending flags for rs/rt (post-update)
//   RegWrite, rd,
//   dataToWrite          : writeback port, clears the pending flag of rd
//   issue_en, issue_rd   : mark issue_rd as pending
//   busy_vec             : scoreboard register
module regbank_param import regbank_pkg::*; #(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int unsigned ZERO_REG   = 1,
  localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] dataToWrite,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
  logic                  busy1_q, busy1_d;
  logic                  busy2_q, busy2_d;
  logic [NUM_REGS-1:0]   busy_next;
  logic                  we_eff;

  // Writes to a hardwired register 0 are dropped here, which also keeps
  // them out of the forwarding path.
  assign we_eff = RegWrite && !((ZERO_REG != 0) && (rd == '0));

  regbank_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clock     (clock),
    .reset_n   (reset_n),
    .set_en    (issue_en),
    .set_idx   (issue_rd),
    .clr_en    (we_eff),
    .clr_idx   (rd),
    .busy_vec  (busy_vec),
    .busy_next (busy_next)
  );

  // Busy flags are taken from the scoreboard's next state, which already
  // carries the same-edge clear/set, so they follow the forwarding rules.
  always_comb begin
    data1_d = data1_q;
    data2_d = data2_q;
    busy1_d = busy1_q;
    busy2_d = busy2_q;
    if (rd_en) begin
      data1_d = (we_eff && (rd == rs)) ? dataToWrite : regs_q[rs];
      data2_d = (we_eff && (rd == rt)) ? dataToWrite : regs_q[rt];
      busy1_d = busy_next[rs];
      busy2_d = busy_next[rt];
      if ((ZERO_REG != 0) && (rs == '0)) data1_d = '0;
      if ((ZERO_REG != 0) && (rt == '0)) data2_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_eff) begin
      regs_q[rd] <= dataToWrite;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data1_q <= '0;
      data2_q <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
    end
  end

  assign data1 = data1_q;
  assign data2 = data2_q;
  assign busy1 = busy1_q;
  assign busy2 = busy2_q;

endmodule
